// File: rtl/bsg_cgol_problem_sender_if.sv
// Handshake/bus bundle between the host-side problem source and the
// problem sender: parallel problem in, serialized 64-bit words out.
interface bsg_cgol_problem_sender_if #(
   parameter int board_width_p     = 16,
   parameter int max_game_length_p = 10
);
   localparam int CELLS   = board_width_p * board_width_p;
   localparam int FW_RAW  = $clog2(max_game_length_p + 1);
   localparam int FW      = (FW_RAW < 1) ? 1 : FW_RAW;

   logic [CELLS-1:0] board_i;
   logic [23:0]      start_end_i;
   logic [FW-1:0]    frames_i;
   logic             v_i;
   logic             ready_o;
   logic [63:0]      data_o;
   logic             v_o;
   logic             ready_i;
   logic             done_o;

   // Host side: presents the problem, consumes the word stream
   modport master (
      output board_i, start_end_i, frames_i, v_i, ready_i,
      input  ready_o, data_o, v_o, done_o
   );

   // Sender side
   modport slave (
      input  board_i, start_end_i, frames_i, v_i, ready_i,
      output ready_o, data_o, v_o, done_o
   );
endinterface

// File: rtl/bsg_cgol_problem_sender.sv
// Captures one path-planning problem (board, start/goal, frame count) and
// serializes it as a header word followed by zero-padded board words.
module bsg_cgol_problem_sender #(
   parameter int board_width_p     = 16,
   parameter int max_game_length_p = 10
) (
   input logic                      clk_i,
   input logic                      reset_n_i,
   bsg_cgol_problem_sender_if.slave io
);
   localparam int CELLS      = board_width_p * board_width_p;
   localparam int BODY_WORDS = (CELLS + 63) / 64;
   localparam int PADW       = BODY_WORDS * 64;
   localparam int FW_RAW     = $clog2(max_game_length_p + 1);
   localparam int FW         = (FW_RAW < 1) ? 1 : FW_RAW;
   localparam int CW_RAW     = $clog2(BODY_WORDS + 1);
   localparam int CW         = (CW_RAW < 1) ? 1 : CW_RAW;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_SEND = 1'b1
   } state_e;

   state_e           r_state;
   logic [CELLS-1:0] r_board;
   logic [CW-1:0]    r_cnt;
   logic [63:0]      r_data;
   logic             r_v;
   logic             r_ready;

   logic [63:0]      w_header;
   logic [PADW-1:0]  w_padded;
   logic [63:0]      w_next_body;
   logic             w_last;

   assign w_padded = PADW'(r_board);
   assign w_last   = (r_cnt == CW'(BODY_WORDS));

   // Header word assembled straight from the inputs at acceptance
   always_comb begin
      w_header           = '0;
      w_header[23:0]     = io.start_end_i;
      w_header[24 +: FW] = io.frames_i;
   end

   // Board word following the one currently on data_o (body word r_cnt)
   always_comb begin
      w_next_body = '0;
      for (int unsigned k = 0; k < BODY_WORDS; k++) begin
         if (r_cnt == CW'(k)) w_next_body = w_padded[k*64 +: 64];
      end
   end

   // Control FSM; data_o is preloaded one word ahead so it comes only from flops
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state <= S_IDLE;
         r_board <= '0;
         r_cnt   <= '0;
         r_data  <= '0;
         r_v     <= 1'b0;
         r_ready <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (io.v_i && r_ready) begin
                  r_board <= io.board_i;
                  r_cnt   <= '0;
                  r_data  <= w_header;
                  r_v     <= 1'b1;
                  r_ready <= 1'b0;
                  r_state <= S_SEND;
               end
            end
            S_SEND: begin
               if (io.ready_i) begin
                  if (w_last) begin
                     r_cnt   <= '0;
                     r_data  <= '0;
                     r_v     <= 1'b0;
                     r_ready <= 1'b1;
                     r_state <= S_IDLE;
                  end else begin
                     r_cnt  <= r_cnt + 1'b1;
                     r_data <= w_next_body;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_v     <= 1'b0;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign io.ready_o = r_ready;
   assign io.v_o     = r_v;
   assign io.data_o  = r_data;
   assign io.done_o  = (r_state == S_SEND) && io.ready_i && w_last;

endmodule

// File: tb/tb_bsg_cgol_problem_sender.sv
// Directed bench for the problem sender: table of problems with
// hand-computed word streams, plus backpressure, hold, reset sequences.
module tb_bsg_cgol_problem_sender;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bsg_cgol_problem_sender_if #(.board_width_p(16), .max_game_length_p(10)) b16 ();
   bsg_cgol_problem_sender_if #(.board_width_p(10), .max_game_length_p(10)) b10 ();

   bsg_cgol_problem_sender #(.board_width_p(16), .max_game_length_p(10)) dut16 (
      .clk_i(clk), .reset_n_i(rst_n), .io(b16));
   bsg_cgol_problem_sender #(.board_width_p(10), .max_game_length_p(10)) dut10 (
      .clk_i(clk), .reset_n_i(rst_n), .io(b10));

   typedef struct packed {
      logic [255:0]     board;
      logic [23:0]      se;
      logic [3:0]       fr;
      logic [4:0][63:0] exp;
   } vec_t;

   vec_t vecs [3];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!b16.ready_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("wait_ready_timeout", 64'(b16.ready_o), 64'd1);
   endtask

   task automatic drive(input int idx);
      b16.board_i     = vecs[idx].board;
      b16.start_end_i = vecs[idx].se;
      b16.frames_i    = vecs[idx].fr;
   endtask

   // Present a problem at a negedge; returns at the negedge the header should show
   task automatic accept(input int idx, input bit hold);
      wait_ready();
      drive(idx);
      b16.v_i = 1'b1;
      @(negedge clk);
      if (!hold) b16.v_i = 1'b0;
   endtask

   task automatic expect_words(input int idx, input bit stall, input bit scramble);
      int k = 0;
      int cyc = 0;
      bit rdy;
      while (k < 5 && cyc < 60) begin
         rdy = stall ? ((cyc >= 2) && (cyc % 2 == 0)) : 1'b1;
         b16.ready_i = rdy;
         if (scramble) b16.board_i = {b16.board_i[254:0], ~b16.board_i[255]};
         #1;
         check("v_o", 64'(b16.v_o), 64'd1);
         check("ready_o_busy", 64'(b16.ready_o), 64'd0);
         check("data_o", b16.data_o, vecs[idx].exp[k]);
         check("done_o", 64'(b16.done_o), 64'(rdy && k == 4));
         @(negedge clk);
         if (rdy) k++;
         cyc++;
      end
      check("word_count", 64'(k), 64'd5);
      b16.ready_i = 1'b1;
      #1;
      check("idle_ready_o", 64'(b16.ready_o), 64'd1);
      check("idle_v_o", 64'(b16.v_o), 64'd0);
      check("idle_done_o", 64'(b16.done_o), 64'd0);
   endtask

   initial begin
      logic [99:0] cb;
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [99:0] cb;
      vecs[0].board = ~256'h1;
      vecs[0].se    = 24'h0410FF;
      vecs[0].fr    = 4'd5;
      vecs[0].exp   = {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                       64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE,
                       64'h0000_0000_0504_10FF};
      vecs[1].board = {64'h0123_4567_89AB_CDEF, 64'hDEAD_BEEF_CAFE_F00D,
                       64'h0, 64'hFFFF_0000_FFFF_0000};
      vecs[1].se    = 24'hFFFFFF;
      vecs[1].fr    = 4'd10;
      vecs[1].exp   = {64'h0123_4567_89AB_CDEF, 64'hDEAD_BEEF_CAFE_F00D,
                       64'h0, 64'hFFFF_0000_FFFF_0000,
                       64'h0000_0000_0AFF_FFFF};
      vecs[2].board = {4{64'h8000_0000_0000_0001}};
      vecs[2].se    = 24'h000001;
      vecs[2].fr    = 4'd1;
      vecs[2].exp   = {64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001,
                       64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001,
                       64'h0000_0000_0100_0001};

      b16.board_i = '0; b16.start_end_i = '0; b16.frames_i = '0;
      b16.v_i = 1'b0; b16.ready_i = 1'b0;
      b10.board_i = '0; b10.start_end_i = '0; b10.frames_i = '0;
      b10.v_i = 1'b0; b10.ready_i = 1'b0;

      // Reset values
      @(negedge clk);
      check("rst_ready_o", 64'(b16.ready_o), 64'd1);
      check("rst_v_o", 64'(b16.v_o), 64'd0);
      check("rst_data_o", b16.data_o, 64'd0);
      check("rst_done_o", 64'(b16.done_o), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Table of problems; the second one is sent under backpressure
      for (int i = 0; i < 3; i++) begin
         accept(i, 1'b0);
         expect_words(i, i == 1, 1'b0);
      end

      // 10x10 checkerboard: 100 cells, last word padded above bit 35
      for (int i = 0; i < 100; i++) cb[i] = (i % 2 == 1);
      b10.board_i = cb; b10.start_end_i = 24'h123456; b10.frames_i = 4'd3;
      b10.ready_i = 1'b1; b10.v_i = 1'b1;
      @(negedge clk);
      b10.v_i = 1'b0;
      check("n10_hdr", b10.data_o, 64'h0000_0000_0312_3456);
      check("n10_hdr_v", 64'(b10.v_o), 64'd1);
      @(negedge clk);
      check("n10_w1", b10.data_o, 64'hAAAA_AAAA_AAAA_AAAA);
      check("n10_w1_done", 64'(b10.done_o), 64'd0);
      @(negedge clk);
      check("n10_w2", b10.data_o, 64'h0000_000A_AAAA_AAAA);
      check("n10_w2_done", 64'(b10.done_o), 64'd1);
      @(negedge clk);
      check("n10_idle_v", 64'(b10.v_o), 64'd0);
      check("n10_idle_ready", 64'(b10.ready_o), 64'd1);

      // v_i held high with a changing board: capture only at acceptance
      accept(0, 1'b1);
      expect_words(0, 1'b0, 1'b1);
      drive(2);
      @(negedge clk);
      #1;
      check("b2b_v_o", 64'(b16.v_o), 64'd1);
      expect_words(2, 1'b0, 1'b1);
      b16.v_i = 1'b0;
      @(negedge clk);
      #1;
      check("no_accept_v_o", 64'(b16.v_o), 64'd0);
      check("no_accept_ready", 64'(b16.ready_o), 64'd1);

      // Asynchronous reset during word 2, then accept on the first edge after release
      accept(1, 1'b0);
      @(negedge clk);
      @(negedge clk);
      check("pre_rst_w2", b16.data_o, vecs[1].exp[2]);
      #2 rst_n = 1'b0;
      #1;
      check("arst_v_o", 64'(b16.v_o), 64'd0);
      check("arst_ready_o", 64'(b16.ready_o), 64'd1);
      check("arst_done_o", 64'(b16.done_o), 64'd0);
      check("arst_data_o", b16.data_o, 64'd0);
      drive(0);
      b16.v_i = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      b16.v_i = 1'b0;
      expect_words(0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
